// File: rtl/word_2_byte.sv
// Word-to-byte serializer: splits each 16-bit word into two bytes, high byte first,
// with a one-word holding buffer and a pulse/busy handshake toward the byte sink.
module word_2_byte (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        word_dv,
    input  logic [15:0] word,
    output logic        word_ready,
    output logic        byte_dv,
    output logic [7:0]  byte_data,
    input  logic        tx_busy,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE,
        HI,
        GAP_HI,
        LO,
        GAP_LO
    } state_t;

    state_t      state;
    logic [15:0] hold;
    logic        hold_valid;
    logic [15:0] shreg;

    assign word_ready = ~hold_valid;
    assign busy       = (state != IDLE) | hold_valid;

    // hold and shreg carry data only; their validity is tracked by hold_valid and state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            byte_dv    <= 1'b0;
            byte_data  <= 8'h00;
            overrun    <= 1'b0;
        end else begin
            byte_dv <= 1'b0;
            if (ce) begin
                // A load only happens with hold_valid=1, an accept only with hold_valid=0,
                // so the two never collide on the same edge.
                if (word_dv) begin
                    if (!hold_valid) begin
                        hold       <= word;
                        hold_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                case (state)
                    IDLE: begin
                        if (hold_valid) begin
                            shreg      <= hold;
                            hold_valid <= 1'b0;
                            state      <= HI;
                        end
                    end
                    HI: begin
                        if (!tx_busy) begin
                            byte_data <= shreg[15:8];
                            byte_dv   <= 1'b1;
                            state     <= GAP_HI;
                        end
                    end
                    GAP_HI: begin
                        state <= LO;
                    end
                    LO: begin
                        if (!tx_busy) begin
                            byte_data <= shreg[7:0];
                            byte_dv   <= 1'b1;
                            state     <= GAP_LO;
                        end
                    end
                    GAP_LO: begin
                        if (hold_valid) begin
                            shreg      <= hold;
                            hold_valid <= 1'b0;
                            state      <= HI;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_word_2_byte.sv
// Bench for word_2_byte: reset/single-word vector table, hand-written corner sequences,
// and a randomized run, all checked every cycle against a byte-queue reference model.
module tb_word_2_byte;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        word_dv = 1'b0;
    logic [15:0] word = 16'h0000;
    logic        tx_busy = 1'b0;
    logic        word_ready;
    logic        byte_dv;
    logic [7:0]  byte_data;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad = 0;

    word_2_byte dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .word_dv   (word_dv),
        .word      (word),
        .word_ready(word_ready),
        .byte_dv   (byte_dv),
        .byte_data (byte_data),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: a buffered word, the bytes still owed from the current word,
    // and a flag for the mandatory quiet edge that follows every issued byte.
    logic        m_hold_v = 1'b0;
    logic [15:0] m_hold = 16'h0000;
    logic [7:0]  m_pend[$];
    logic        m_guard = 1'b0;
    logic [7:0]  m_byte = 8'h00;
    logic        m_dv = 1'b0;
    logic        m_ovr = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic wd,
                        input logic [15:0] w, input logic tb);
        logic hv;
        rst = r; ce = c; word_dv = wd; word = w; tx_busy = tb;
        @(posedge clk);
        m_dv = 1'b0;
        if (r) begin
            m_hold_v = 1'b0;
            m_pend.delete();
            m_guard = 1'b0;
            m_byte = 8'h00;
            m_ovr = 1'b0;
        end else if (c) begin
            hv = m_hold_v;
            if (m_pend.size() != 0) begin
                if (m_guard) m_guard = 1'b0;
                else if (!tb) begin
                    m_byte = m_pend.pop_front();
                    m_dv = 1'b1;
                    m_guard = 1'b1;
                end
            end else begin
                m_guard = 1'b0;
                if (hv) begin
                    m_pend.push_back(m_hold[15:8]);
                    m_pend.push_back(m_hold[7:0]);
                    m_hold_v = 1'b0;
                end
            end
            if (wd) begin
                if (!hv) begin
                    m_hold = w;
                    m_hold_v = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        #1;
        chk("model byte_dv", byte_dv, m_dv);
        chk("model byte", byte_data, m_byte);
        chk("model busy", busy, (m_pend.size() != 0) || m_guard || m_hold_v);
        chk("model word_ready", word_ready, !m_hold_v);
        chk("model overrun", overrun, m_ovr);
    endtask

    typedef struct {
        logic        r, c, wd;
        logic [15:0] w;
        logic        tb;
        logic        e_dv;
        logic [7:0]  e_byte;
        logic        e_busy, e_ready, e_ovr;
    } vec_t;

    vec_t       tbl[10];
    logic [7:0] b2b[4];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 16'hA55A, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
        b2b = '{8'h12, 8'h34, 8'hAB, 8'hCD};

        // Reset with word_dv held, then a single word A55A.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].c, tbl[i].wd, tbl[i].w, tbl[i].tb);
            chk($sformatf("tbl[%0d] byte_dv", i), byte_dv, tbl[i].e_dv);
            chk($sformatf("tbl[%0d] byte", i), byte_data, tbl[i].e_byte);
            chk($sformatf("tbl[%0d] busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl[%0d] word_ready", i), word_ready, tbl[i].e_ready);
            chk($sformatf("tbl[%0d] overrun", i), overrun, tbl[i].e_ovr);
        end

        // Back-to-back: 1234 then ABCD offered as soon as word_ready returns.
        step(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("b2b ready after transfer", word_ready, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'hABCD, 1'b0);
        chk("b2b dv edge2", byte_dv, 1'b1);
        chk("b2b byte edge2", byte_data, b2b[0]);
        for (int k = 3; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
            if (k % 2 == 0) begin
                chk($sformatf("b2b dv edge%0d", k), byte_dv, 1'b1);
                chk($sformatf("b2b byte edge%0d", k), byte_data, b2b[k/2-1]);
            end else begin
                chk($sformatf("b2b dv edge%0d", k), byte_dv, 1'b0);
            end
        end
        chk("b2b busy end", busy, 1'b0);
        chk("b2b overrun", overrun, 1'b0);

        // Stall: tx_busy high for 10 cycles while the high byte is pending.
        step(1'b0, 1'b1, 1'b1, 16'h3C96, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
            chk("stall no dv", byte_dv, 1'b0);
            chk("stall byte held", byte_data, 8'hCD);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("stall release dv", byte_dv, 1'b1);
        chk("stall release byte", byte_data, 8'h3C);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("stall low byte", byte_data, 8'h96);

        // Overrun: DEAD offered while the buffer is full.
        step(1'b0, 1'b1, 1'b1, 16'h1111, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h2222, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b0);
        chk("ovr set", overrun, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
            chk("ovr no dead byte", byte_dv && (byte_data == 8'hDE || byte_data == 8'hAD), 1'b0);
        end
        chk("ovr sticky", overrun, 1'b1);
        chk("ovr last byte", byte_data, 8'h22);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("ovr cleared by rst", overrun, 1'b0);

        // ce low for 5 cycles in the gap after the high byte; a word offered then is ignored.
        step(1'b0, 1'b1, 1'b1, 16'h6E81, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("ce hi byte", byte_data, 8'h6E);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
            chk("ce frozen dv", byte_dv, 1'b0);
            chk("ce frozen ready", word_ready, 1'b1);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("ce gap dv", byte_dv, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("ce lo dv", byte_dv, 1'b1);
        chk("ce lo byte", byte_data, 8'h81);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("ce idle", busy, 1'b0);

        // Reset while waiting to send the low byte.
        step(1'b0, 1'b1, 1'b1, 16'hC3B7, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("rst lo dv", byte_dv, 1'b0);
        chk("rst lo busy", busy, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("rst lo no late dv", byte_dv, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h0F0F, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("after rst hi dv", byte_dv, 1'b1);
        chk("after rst hi byte", byte_data, 8'h0F);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("after rst lo dv", byte_dv, 1'b1);
        chk("after rst lo byte", byte_data, 8'h0F);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
